player_motion_controller: RTL and testbench

PLAYER_MOTION_CONTROLLER -- requirements
Module: player_motion_controller

---
 rtl/fq_pkg.sv | 23 ++
 rtl/player_motion_controller_if.sv | 30 +++
 rtl/player_axis.sv | 46 ++++
 rtl/player_motion_controller.sv | 169 ++++++++++++++++
 tb/tb_player_motion_controller.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fq_pkg.sv
// Shared constants and helpers for the player motion controller: coordinate
// width, default playfield bounds and the sprite-overlap test.
package fq_pkg;

   localparam int POS_W     = 10;
   localparam int X_MIN_DEF = 0;
   localparam int X_MAX_DEF = 639;
   localparam int Y_MIN_DEF = 0;
   localparam int Y_MAX_DEF = 479;

   typedef logic [POS_W-1:0] pos_t;

   // Two square sprites of half-size r overlap when both centre distances are below 2r.
   function automatic logic too_close(input int ax, input int ay,
                                      input int bx, input int by, input int r);
      int dx;
      int dy;
      dx = (ax > bx) ? ax - bx : bx - ax;
      dy = (ay > by) ? ay - by : by - ay;
      return (dx < 2 * r) && (dy < 2 * r);
   endfunction

endpackage

// File: rtl/player_motion_controller_if.sv
// Signal bundle around the player motion controller: button/freeze inputs
// from the master side, positions and pulses back from the controller.
interface player_motion_controller_if
   import fq_pkg::*;
#(
   parameter int NUM_PLAYERS = 2,
   parameter int POS_W       = fq_pkg::POS_W
);

   logic [NUM_PLAYERS-1:0]       btn_up;
   logic [NUM_PLAYERS-1:0]       btn_down;
   logic [NUM_PLAYERS-1:0]       btn_left;
   logic [NUM_PLAYERS-1:0]       btn_right;
   logic                         freeze;
   logic [NUM_PLAYERS*POS_W-1:0] pos_x;
   logic [NUM_PLAYERS*POS_W-1:0] pos_y;
   logic [NUM_PLAYERS-1:0]       moving;
   logic                         tick;

   modport master (
      output btn_up, btn_down, btn_left, btn_right, freeze,
      input  pos_x, pos_y, moving, tick
   );

   modport slave (
      input  btn_up, btn_down, btn_left, btn_right, freeze,
      output pos_x, pos_y, moving, tick
   );

endinterface

// File: rtl/player_axis.sv
// One coordinate of one player: step by +/-STEP from a synchronized button
// pair and saturate the result into [LO, HI].
module player_axis
   import fq_pkg::*;
#(
   parameter int POS_W = fq_pkg::POS_W,
   parameter int STEP  = 1,
   parameter int LO    = 25,
   parameter int HI    = 614
)(
   input  logic [POS_W-1:0] pos,
   input  logic             dec,
   input  logic             inc,
   output logic [POS_W-1:0] cand
);

   localparam int W1 = POS_W + 1;
   localparam logic signed [POS_W:0] STEP_S = W1'(STEP);
   localparam logic signed [POS_W:0] LO_S   = W1'(LO);
   localparam logic signed [POS_W:0] HI_S   = W1'(HI);

   logic signed [POS_W:0] pos_s;
   logic signed [POS_W:0] sum_s;

   // An idle or conflicting axis holds its position untouched; only a real step is clamped.
   always_comb begin
      pos_s = $signed({1'b0, pos});
      sum_s = pos_s;
      cand  = pos;
      if (inc && !dec) begin
         sum_s = pos_s + STEP_S;
      end else if (dec && !inc) begin
         sum_s = pos_s - STEP_S;
      end
      if (inc ^ dec) begin
         if (sum_s < LO_S) begin
            cand = LO_S[POS_W-1:0];
         end else if (sum_s > HI_S) begin
            cand = HI_S[POS_W-1:0];
         end else begin
            cand = sum_s[POS_W-1:0];
         end
      end
   end

endmodule

// File: rtl/player_motion_controller.sv
// Moves NUM_PLAYERS sprites from debounced-by-sync buttons once per MOVE_PERIOD.
// Define PLAYER_COLLISION_EN to stop players from stepping into each other.
module player_motion_controller
   import fq_pkg::*;
#(
   parameter int NUM_PLAYERS   = 2,
   parameter int POS_W         = fq_pkg::POS_W,
   parameter int PLAYER_RADIUS = 25,
   parameter int MOVE_PERIOD   = 100000,
   parameter int STEP          = 1,
   parameter int X_MIN         = fq_pkg::X_MIN_DEF,
   parameter int X_MAX         = fq_pkg::X_MAX_DEF,
   parameter int Y_MIN         = fq_pkg::Y_MIN_DEF,
   parameter int Y_MAX         = fq_pkg::Y_MAX_DEF,
   parameter int INIT_Y        = 250,
   parameter int INIT_X_BASE   = 300,
   parameter int INIT_X_STEP   = 400
)(
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NUM_PLAYERS-1:0]       btn_up,
   input  logic [NUM_PLAYERS-1:0]       btn_down,
   input  logic [NUM_PLAYERS-1:0]       btn_left,
   input  logic [NUM_PLAYERS-1:0]       btn_right,
   input  logic                         freeze,
   output logic [NUM_PLAYERS*POS_W-1:0] pos_x,
   output logic [NUM_PLAYERS*POS_W-1:0] pos_y,
   output logic [NUM_PLAYERS-1:0]       moving,
   output logic                         tick
);

   localparam int CNT_W = $clog2(MOVE_PERIOD);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MOVE_PERIOD - 1);
   localparam int X_LO = X_MIN + PLAYER_RADIUS;
   localparam int X_HI = X_MAX - PLAYER_RADIUS;
   localparam int Y_LO = Y_MIN + PLAYER_RADIUS;
   localparam int Y_HI = Y_MAX - PLAYER_RADIUS;
   localparam int NB   = 4 * NUM_PLAYERS;

   logic [CNT_W-1:0]       count_q, count_d;
   logic [NB-1:0]          sync1_q, sync1_d;
   logic [NB-1:0]          sync2_q, sync2_d;
   logic [NUM_PLAYERS-1:0] moving_q, moving_d;
   logic [POS_W-1:0]       x_q [NUM_PLAYERS];
   logic [POS_W-1:0]       x_d [NUM_PLAYERS];
   logic [POS_W-1:0]       y_q [NUM_PLAYERS];
   logic [POS_W-1:0]       y_d [NUM_PLAYERS];
   logic [POS_W-1:0]       cand_x [NUM_PLAYERS];
   logic [POS_W-1:0]       cand_y [NUM_PLAYERS];
   logic [POS_W-1:0]       acc_x [NUM_PLAYERS];
   logic [POS_W-1:0]       acc_y [NUM_PLAYERS];
   logic                   tick_int;

   assign tick_int = rst_n && !freeze && (count_q == CNT_LAST);
   assign tick     = tick_int;
   assign moving   = moving_q;

   // Synchronized button bundle layout: {right, left, down, up}, NUM_PLAYERS bits each.
   for (genvar gi = 0; gi < NUM_PLAYERS; gi++) begin : g_player
      player_axis #(
         .POS_W (POS_W),
         .STEP  (STEP),
         .LO    (X_LO),
         .HI    (X_HI)
      ) u_axis_x (
         .pos   (x_q[gi]),
         .dec   (sync2_q[2*NUM_PLAYERS + gi]),
         .inc   (sync2_q[3*NUM_PLAYERS + gi]),
         .cand  (cand_x[gi])
      );

      player_axis #(
         .POS_W (POS_W),
         .STEP  (STEP),
         .LO    (Y_LO),
         .HI    (Y_HI)
      ) u_axis_y (
         .pos   (y_q[gi]),
         .dec   (sync2_q[gi]),
         .inc   (sync2_q[NUM_PLAYERS + gi]),
         .cand  (cand_y[gi])
      );

      assign pos_x[gi*POS_W +: POS_W] = x_q[gi];
      assign pos_y[gi*POS_W +: POS_W] = y_q[gi];
   end

`ifdef PLAYER_COLLISION_EN
   // Lower-index players claim their spot first; a blocked player keeps both coordinates.
   always_comb begin
      logic             blocked;
      logic [POS_W-1:0] ax [NUM_PLAYERS];
      logic [POS_W-1:0] ay [NUM_PLAYERS];
      blocked = 1'b0;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
         ax[i] = x_q[i];
         ay[i] = y_q[i];
      end
      for (int i = 0; i < NUM_PLAYERS; i++) begin
         blocked = 1'b0;
         for (int j = 0; j < NUM_PLAYERS; j++) begin
            if (j != i && too_close(int'(cand_x[i]), int'(cand_y[i]),
                                    int'(x_q[j]), int'(y_q[j]), PLAYER_RADIUS)) begin
               blocked = 1'b1;
            end
            if (j < i && too_close(int'(cand_x[i]), int'(cand_y[i]),
                                   int'(ax[j]), int'(ay[j]), PLAYER_RADIUS)) begin
               blocked = 1'b1;
            end
         end
         ax[i] = blocked ? x_q[i] : cand_x[i];
         ay[i] = blocked ? y_q[i] : cand_y[i];
      end
      for (int i = 0; i < NUM_PLAYERS; i++) begin
         acc_x[i] = ax[i];
         acc_y[i] = ay[i];
      end
   end
`else
   always_comb begin
      for (int i = 0; i < NUM_PLAYERS; i++) begin
         acc_x[i] = cand_x[i];
         acc_y[i] = cand_y[i];
      end
   end
`endif

   always_comb begin
      sync1_d  = {btn_right, btn_left, btn_down, btn_up};
      sync2_d  = sync1_q;
      count_d  = count_q;
      moving_d = '0;
      if (!freeze) begin
         count_d = (count_q == CNT_LAST) ? '0 : count_q + 1'b1;
      end
      for (int i = 0; i < NUM_PLAYERS; i++) begin
         x_d[i] = x_q[i];
         y_d[i] = y_q[i];
         if (tick_int) begin
            x_d[i]      = acc_x[i];
            y_d[i]      = acc_y[i];
            moving_d[i] = (acc_x[i] != x_q[i]) || (acc_y[i] != y_q[i]);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q  <= '0;
         sync1_q  <= '0;
         sync2_q  <= '0;
         moving_q <= '0;
         for (int i = 0; i < NUM_PLAYERS; i++) begin
            x_q[i] <= POS_W'(INIT_X_BASE + i * INIT_X_STEP);
            y_q[i] <= POS_W'(INIT_Y);
         end
      end else begin
         count_q  <= count_d;
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         moving_q <= moving_d;
         for (int i = 0; i < NUM_PLAYERS; i++) begin
            x_q[i] <= x_d[i];
            y_q[i] <= y_d[i];
         end
      end
   end

endmodule

// File: tb/tb_player_motion_controller.sv
// Bench for player_motion_controller: three instances (default, STEP=3 near the
// bottom bound, players 50 px apart) against one behavioural model, directed then random.
module tb_player_motion_controller;

   localparam int NI = 3;
   localparam int NP = 2;
   localparam int PW = 10;
   localparam int MP = 4;
   localparam int R  = 25;
   localparam int XLO = 0 + R;
   localparam int XHI = 639 - R;
   localparam int YLO = 0 + R;
   localparam int YHI = 479 - R;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   player_motion_controller_if #(.NUM_PLAYERS(NP), .POS_W(PW)) bus ();

   logic [NP*PW-1:0] px [NI];
   logic [NP*PW-1:0] py [NI];
   logic [NP-1:0]    mv [NI];
   logic             tk [NI];

   player_motion_controller #(
      .NUM_PLAYERS(NP), .POS_W(PW), .PLAYER_RADIUS(R), .MOVE_PERIOD(MP), .STEP(1),
      .X_MIN(0), .X_MAX(639), .Y_MIN(0), .Y_MAX(479),
      .INIT_Y(250), .INIT_X_BASE(300), .INIT_X_STEP(400)
   ) dut_a (
      .clk(clk), .rst_n(rst_n),
      .btn_up(bus.btn_up), .btn_down(bus.btn_down),
      .btn_left(bus.btn_left), .btn_right(bus.btn_right),
      .freeze(bus.freeze),
      .pos_x(bus.pos_x), .pos_y(bus.pos_y), .moving(bus.moving), .tick(bus.tick)
   );

   player_motion_controller #(
      .NUM_PLAYERS(NP), .POS_W(PW), .PLAYER_RADIUS(R), .MOVE_PERIOD(MP), .STEP(3),
      .X_MIN(0), .X_MAX(639), .Y_MIN(0), .Y_MAX(479),
      .INIT_Y(453), .INIT_X_BASE(300), .INIT_X_STEP(400)
   ) dut_b (
      .clk(clk), .rst_n(rst_n),
      .btn_up(bus.btn_up), .btn_down(bus.btn_down),
      .btn_left(bus.btn_left), .btn_right(bus.btn_right),
      .freeze(bus.freeze),
      .pos_x(px[1]), .pos_y(py[1]), .moving(mv[1]), .tick(tk[1])
   );

   player_motion_controller #(
      .NUM_PLAYERS(NP), .POS_W(PW), .PLAYER_RADIUS(R), .MOVE_PERIOD(MP), .STEP(1),
      .X_MIN(0), .X_MAX(639), .Y_MIN(0), .Y_MAX(479),
      .INIT_Y(250), .INIT_X_BASE(300), .INIT_X_STEP(50)
   ) dut_c (
      .clk(clk), .rst_n(rst_n),
      .btn_up(bus.btn_up), .btn_down(bus.btn_down),
      .btn_left(bus.btn_left), .btn_right(bus.btn_right),
      .freeze(bus.freeze),
      .pos_x(px[2]), .pos_y(py[2]), .moving(mv[2]), .tick(tk[2])
   );

   assign px[0] = bus.pos_x;
   assign py[0] = bus.pos_y;
   assign mv[0] = bus.moving;
   assign tk[0] = bus.tick;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int i_step(input int k);
      return (k == 1) ? 3 : 1;
   endfunction
   function automatic int i_inity(input int k);
      return (k == 1) ? 453 : 250;
   endfunction
   function automatic int i_xstep(input int k);
      return (k == 2) ? 50 : 400;
   endfunction
   function automatic int clampi(input int v, input int lo, input int hi);
      return (v < lo) ? lo : ((v > hi) ? hi : v);
   endfunction
   function automatic bit near(input int ax, input int ay, input int bx, input int by);
      int dx;
      int dy;
      dx = (ax > bx) ? ax - bx : bx - ax;
      dy = (ay > by) ? ay - by : by - ay;
      return (dx < 2 * R) && (dy < 2 * R);
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // Reference model: raw buttons become visible two edges after sampling.
   int              mx [NI][NP];
   int              my [NI][NP];
   bit [NP-1:0]     mmov [NI];
   int              mcnt;
   logic [4*NP-1:0] seen1;
   logic [4*NP-1:0] seen2;
   bit              mvalid = 1'b0;

   always @(posedge clk) begin : model
      bit tick_now;
      int nx [NP];
      int ny [NP];
      int dx;
      int dy;
      bit blocked;
      if (!rst_n) begin
         mcnt  = 0;
         seen1 = '0;
         seen2 = '0;
         for (int k = 0; k < NI; k++) begin
            mmov[k] = '0;
            for (int i = 0; i < NP; i++) begin
               mx[k][i] = 300 + i * i_xstep(k);
               my[k][i] = i_inity(k);
            end
         end
         mvalid = 1'b1;
      end else begin
         tick_now = (mcnt == MP - 1) && !bus.freeze;
         for (int k = 0; k < NI; k++) begin
            mmov[k] = '0;
            if (tick_now) begin
               for (int i = 0; i < NP; i++) begin
                  dx = (seen2[3*NP+i] ? i_step(k) : 0) - (seen2[2*NP+i] ? i_step(k) : 0);
                  dy = (seen2[NP+i] ? i_step(k) : 0) - (seen2[i] ? i_step(k) : 0);
                  nx[i] = (dx != 0) ? clampi(mx[k][i] + dx, XLO, XHI) : mx[k][i];
                  ny[i] = (dy != 0) ? clampi(my[k][i] + dy, YLO, YHI) : my[k][i];
               end
`ifdef PLAYER_COLLISION_EN
               for (int i = 0; i < NP; i++) begin
                  blocked = 1'b0;
                  for (int j = 0; j < NP; j++) begin
                     if (j != i && near(nx[i], ny[i], mx[k][j], my[k][j])) blocked = 1'b1;
                     if (j < i && near(nx[i], ny[i], nx[j], ny[j])) blocked = 1'b1;
                  end
                  if (blocked) begin
                     nx[i] = mx[k][i];
                     ny[i] = my[k][i];
                  end
               end
`else
               blocked = 1'b0;
`endif
               for (int i = 0; i < NP; i++) begin
                  mmov[k][i] = (nx[i] != mx[k][i]) || (ny[i] != my[k][i]);
                  mx[k][i]   = nx[i];
                  my[k][i]   = ny[i];
               end
            end
         end
         if (!bus.freeze) mcnt = (mcnt + 1) % MP;
         seen2 = seen1;
         seen1 = {bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up};
      end
   end

   always @(negedge clk) begin
      if (mvalid) begin
         for (int k = 0; k < NI; k++) begin
            for (int i = 0; i < NP; i++) begin
               chk($sformatf("x%0d_%0d", k, i), 64'(px[k][i*PW +: PW]), 64'(mx[k][i]));
               chk($sformatf("y%0d_%0d", k, i), 64'(py[k][i*PW +: PW]), 64'(my[k][i]));
            end
            chk($sformatf("moving%0d", k), 64'(mv[k]), 64'(mmov[k]));
            chk($sformatf("tick%0d", k), 64'(tk[k]),
                64'(rst_n && (mcnt == MP - 1) && !bus.freeze));
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin : stim
      logic [7:0] r;
      checks = 0;
      errors = 0;
      rst_n = 1'b0;
      bus.btn_up = '0;
      bus.btn_down = '0;
      bus.btn_left = '0;
      bus.btn_right = '0;
      bus.freeze = 1'b0;
      step(2);
      chk("rst_pos_x", 64'(px[0]), 64'({10'd700, 10'd300}));
      chk("rst_pos_y", 64'(py[0]), 64'({10'd250, 10'd250}));
      chk("rst_moving", 64'(mv[0]), 64'd0);
      chk("rst_tick", 64'(tk[0]), 64'd0);
      chk("rst_b_pos_y", 64'(py[1]), 64'({10'd453, 10'd453}));

      rst_n = 1'b1;
      bus.btn_down = 2'b01;
      step(4);
      chk("down_first_tick_y", 64'(py[0][PW-1:0]), 64'd251);
      chk("down_first_moving", 64'(mv[0]), 64'd1);
      chk("bound_b_y", 64'(py[1][PW-1:0]), 64'd454);
      chk("bound_b_moving", 64'(mv[1]), 64'd1);
      step(1);
      chk("moving_clears", 64'(mv[0]), 64'd0);
      step(7);
      chk("down_third_tick_y", 64'(py[0][PW-1:0]), 64'd253);
      chk("bound_b_stays", 64'(py[1][PW-1:0]), 64'd454);
      chk("bound_b_no_pulse", 64'(mv[1]), 64'd0);

      bus.btn_up = 2'b01;
      step(8);
      chk("conflict_y", 64'(py[0][PW-1:0]), 64'd253);
      chk("conflict_moving", 64'(mv[0]), 64'd0);
      bus.btn_up = 2'b00;
      step(1);
      bus.freeze = 1'b1;
      step(20);
      chk("freeze_y_held", 64'(py[0][PW-1:0]), 64'd253);
      chk("freeze_no_tick", 64'(tk[0]), 64'd0);
      bus.freeze = 1'b0;
      step(2);
      chk("freeze_resume_tick", 64'(tk[0]), 64'd1);
      step(1);
      chk("freeze_resume_y", 64'(py[0][PW-1:0]), 64'd254);

      bus.btn_right = 2'b01;
      step(4);
`ifdef PLAYER_COLLISION_EN
      chk("collision_x0", 64'(px[2][PW-1:0]), 64'd300);
`else
      chk("collision_x0", 64'(px[2][PW-1:0]), 64'd301);
`endif

      bus.btn_down = '0;
      bus.btn_right = '0;
      for (int c = 0; c < 6000; c++) begin
         if ($urandom_range(7) == 0) begin
            r = 8'($urandom);
            {bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up} = r;
         end
         if (bus.freeze) bus.freeze = ($urandom_range(5) != 0);
         else bus.freeze = ($urandom_range(39) == 0);
         rst_n = ($urandom_range(299) != 0);
         step(1);
      end
      rst_n = 1'b1;
      step(2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
